// File: rtl/mvu_pkg.sv
// rtl/mvu_pkg.sv - shared MVU result-path types and default widths
package mvu_pkg;

    localparam int MVU_DATA_W = 64;
    localparam int MVU_ADDR_W = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN,
        ST_DONE
    } collector_state_t;

    typedef struct packed {
        logic                  last;
        logic [MVU_ADDR_W-1:0] addr;
        logic [MVU_DATA_W-1:0] data;
    } result_entry_t;

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - result FIFO with zeroed head output and a tag-last-written port
module result_fifo
    import mvu_pkg::*;
#(
    parameter int DATA_W = MVU_DATA_W,
    parameter int ADDR_W = MVU_ADDR_W,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              wr_last_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_accept_o,
    input  logic              set_last_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              rd_last_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              pop_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + ADDR_W + DATA_W;

    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] wr_idx, rd_idx, last_idx;
    logic          full, empty, pop;

    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign last_idx = wr_idx - AW'(1);

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign pop   = !empty && rd_ready_i;

    assign wr_accept_o = wr_en_i && (!full || pop);
    assign pop_o       = pop;
    assign empty_o     = empty;

    assign head       = mem_q[rd_idx];
    assign rd_valid_o = !empty;
    assign rd_last_o  = !empty && head[EW-1];
    assign rd_addr_o  = empty ? '0 : head[EW-2 -: ADDR_W];
    assign rd_data_o  = empty ? '0 : head[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_accept_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)         rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: nothing is visible unless the pointers say so.
    always_ff @(posedge clk) begin
        if (wr_accept_o) mem_q[wr_idx] <= {wr_last_i, wr_addr_i, wr_data_i};
        if (set_last_i && !empty) mem_q[last_idx][EW-1] <= 1'b1;
    end

endmodule

// File: rtl/mvu_result_collector.sv
// rtl/mvu_result_collector.sv - captures MVU output words, buffers them and signals job completion
module mvu_result_collector
    import mvu_pkg::*;
#(
    parameter int DATA_W = MVU_DATA_W,
    parameter int ADDR_W = MVU_ADDR_W,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mvu_wr_en,
    input  logic [ADDR_W-1:0] mvu_wr_addr,
    input  logic [DATA_W-1:0] mvu_wr_data,
    input  logic              mvu_done,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              job_irq,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              overflow,
    input  logic              clr_err
);
    collector_state_t state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             overflow_q, overflow_d;
    logic             job_irq_q;

    logic push_req, push_last, push_accept, set_last, drop;
    logic fifo_pop, fifo_empty;

    result_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (push_req),
        .wr_last_i   (push_last),
        .wr_addr_i   (mvu_wr_addr),
        .wr_data_i   (mvu_wr_data),
        .wr_accept_o (push_accept),
        .set_last_i  (set_last),
        .rd_valid_o  (rd_valid),
        .rd_ready_i  (rd_ready),
        .rd_last_o   (rd_last),
        .rd_addr_o   (rd_addr),
        .rd_data_o   (rd_data),
        .pop_o       (fifo_pop),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        push_req   = 1'b0;
        push_last  = 1'b0;
        set_last   = 1'b0;
        drop       = 1'b0;
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mvu_wr_en) begin
                    push_req   = 1'b1;
                    push_last  = mvu_done;
                    word_cnt_d = push_accept ? CNT_W'(1) : '0;
                    state_d    = mvu_done ? ST_DRAIN : ST_COLLECT;
                end else if (mvu_done) begin
                    word_cnt_d = '0;
                    state_d    = ST_DONE;
                end
            end
            ST_COLLECT: begin
                if (mvu_wr_en) begin
                    push_req  = 1'b1;
                    push_last = mvu_done;
                    if (push_accept && word_cnt_q != '1)
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                end
                if (mvu_done) begin
                    set_last = !mvu_wr_en;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drop = mvu_wr_en;
                // Empty covers jobs whose last word was dropped or already popped.
                if ((fifo_pop && rd_last) || fifo_empty)
                    state_d = ST_DONE;
            end
            default: begin
                drop    = mvu_wr_en;
                state_d = ST_IDLE;
            end
        endcase
        if (push_req && !push_accept) drop = 1'b1;
        overflow_d = drop ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            overflow_q <= 1'b0;
            job_irq_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            overflow_q <= overflow_d;
            job_irq_q  <= (state_d == ST_DONE);
        end
    end

    assign job_irq  = job_irq_q;
    assign word_cnt = word_cnt_q;
    assign overflow = overflow_q;

endmodule
